// File: rtl/alu_check_pkg.sv
// Shared types and defaults for the ALU lockstep checker.
// CHECK_FLAGS_EN widens the compare to the zero/negative flags.
package alu_check_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FUNC_W_DEF = 3;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_SUB  = 3'd1;
    localparam logic [2:0] FN_AND  = 3'd2;
    localparam logic [2:0] FN_OR   = 3'd3;
    localparam logic [2:0] FN_XOR  = 3'd4;
    localparam logic [2:0] FN_SHL  = 3'd5;
    localparam logic [2:0] FN_SHR  = 3'd6;
    localparam logic [2:0] FN_PASS = 3'd7;

endpackage

// File: rtl/alu_result_cmp.sv
// Combinational verdict for one behavioral/structural result pair.
// CHECK_FLAGS_EN adds flag agreement and per-ALU flag consistency.
module alu_result_cmp
    import alu_check_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] wb,
    input  logic [DATA_W-1:0] ws,
    input  logic              zb,
    input  logic              nb,
    input  logic              zs,
    input  logic              ns,
    output logic              fail
);

`ifdef CHECK_FLAGS_EN
    logic flag_diff;
    logic self_b;
    logic self_s;

    always_comb begin
        flag_diff = (zb != zs) | (nb != ns);
        self_b    = (zb != (wb == '0)) | (nb != wb[DATA_W-1]);
        self_s    = (zs != (ws == '0)) | (ns != ws[DATA_W-1]);
        fail      = (wb != ws) | flag_diff | self_b | self_s;
    end
`else
    logic unused_flags;

    assign unused_flags = ^{zb, nb, zs, ns};
    assign fail         = (wb != ws);
`endif

endmodule

// File: rtl/alu_lockstep_checker.sv
// Streams vectors through a 2-stage compare pipeline and keeps run stats.
// Optional CHECK_FLAGS_EN (in alu_result_cmp) also checks ALU flags.
module alu_lockstep_checker
    import alu_check_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FUNC_W = FUNC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vectors,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      a,
    input  logic [DATA_W-1:0]      b,
    input  logic                   cin,
    input  logic [FUNC_W-1:0]      func,
    input  logic [DATA_W-1:0]      wb,
    input  logic [DATA_W-1:0]      ws,
    input  logic                   zb,
    input  logic                   nb,
    input  logic                   zs,
    input  logic                   ns,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic                   first_fail_valid,
    output logic [CNT_W-1:0]       first_fail_idx,
    output logic [FUNC_W-1:0]      first_fail_func,
    output logic [(1<<FUNC_W)-1:0] func_fail_mask
);

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] nvec;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] acc_nx;
    logic             xfer;
    logic             start_ok;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_wb;
    logic [DATA_W-1:0] s1_ws;
    logic              s1_zb;
    logic              s1_nb;
    logic              s1_zs;
    logic              s1_ns;
    logic [FUNC_W-1:0] s1_func;
    logic [CNT_W-1:0]  s1_idx;
    logic              s1_fail;

    logic              s2_valid;
    logic              s2_fail;
    logic [FUNC_W-1:0] s2_func;
    logic [CNT_W-1:0]  s2_idx;

    logic unused_ops;

    assign unused_ops = ^{a, b, cin};

    assign start_ok = start & ((state == IDLE) | (state == DONE));
    assign xfer     = in_valid & in_ready;
    assign acc_nx   = accepted + CNT_W'(xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (acc_nx >= nvec) state_nx = DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid) state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN) && (accepted < nvec);
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
        pass     = done && (mismatch_count == '0);
    end

    alu_result_cmp #(
        .DATA_W(DATA_W)
    ) u_cmp (
        .wb  (s1_wb),
        .ws  (s1_ws),
        .zb  (s1_zb),
        .nb  (s1_nb),
        .zs  (s1_zs),
        .ns  (s1_ns),
        .fail(s1_fail)
    );

    // Stage 1 captures the raw results, stage 2 holds the verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_wb    <= '0;
            s1_ws    <= '0;
            s1_zb    <= 1'b0;
            s1_nb    <= 1'b0;
            s1_zs    <= 1'b0;
            s1_ns    <= 1'b0;
            s1_func  <= '0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_fail  <= 1'b0;
            s2_func  <= '0;
            s2_idx   <= '0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_wb   <= wb;
                s1_ws   <= ws;
                s1_zb   <= zb;
                s1_nb   <= nb;
                s1_zs   <= zs;
                s1_ns   <= ns;
                s1_func <= func;
                s1_idx  <= accepted;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_fail <= s1_fail;
                s2_func <= s1_func;
                s2_idx  <= s1_idx;
            end
        end
    end

    // Start only lands in IDLE/DONE, when the pipeline is already empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nvec             <= '0;
            accepted         <= '0;
            mismatch_count   <= '0;
            func_fail_mask   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_func  <= '0;
        end else if (start_ok) begin
            nvec             <= num_vectors;
            accepted         <= '0;
            mismatch_count   <= '0;
            func_fail_mask   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_func  <= '0;
        end else begin
            accepted <= acc_nx;
            if (s2_valid && s2_fail) begin
                if (mismatch_count != '1) begin
                    mismatch_count <= mismatch_count + 1'b1;
                end
                func_fail_mask[s2_func] <= 1'b1;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= s2_idx;
                    first_fail_func  <= s2_func;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// Table-driven runs plus handshake, restart and reset sequences,
// with a per-vector scoreboard on mismatch_count.
module tb_alu_lockstep_checker;

    localparam int DW = 16;
    localparam int FW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_vectors = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          cin = 1'b0;
    logic [FW-1:0] func = '0;
    logic [DW-1:0] wb = '0;
    logic [DW-1:0] ws = '0;
    logic          zb = 1'b0;
    logic          nb = 1'b0;
    logic          zs = 1'b0;
    logic          ns = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] mismatch_count;
    logic          first_fail_valid;
    logic [CW-1:0] first_fail_idx;
    logic [FW-1:0] first_fail_func;
    logic [7:0]    func_fail_mask;

    alu_lockstep_checker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_vectors     (num_vectors),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a               (a),
        .b               (b),
        .cin             (cin),
        .func            (func),
        .wb              (wb),
        .ws              (ws),
        .zb              (zb),
        .nb              (nb),
        .zs              (zs),
        .ns              (ns),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .mismatch_count  (mismatch_count),
        .first_fail_valid(first_fail_valid),
        .first_fail_idx  (first_fail_idx),
        .first_fail_func (first_fail_func),
        .func_fail_mask  (func_fail_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_cnt = 0;
    int exp_q[$];

    // Marks the edge at which a transfer's statistics must be visible.
    logic d1, d2, chk;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1  <= 1'b0;
            d2  <= 1'b0;
            chk <= 1'b0;
        end else begin
            d1  <= in_valid & in_ready;
            d2  <= d1;
            chk <= d2;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        int e;
        @(negedge clk);
        if (chk) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=empty required=entry");
            end else begin
                e = exp_q.pop_front();
                check("sb_count", 64'(mismatch_count), 64'(e));
            end
        end
    endtask

    function automatic bit model_fail(input logic [DW-1:0] w, s,
                                      input logic fzb, fnb, fzs, fns);
        bit f;
        f = (w != s);
`ifdef CHECK_FLAGS_EN
        f = f | (fzb != fzs) | (fnb != fns);
        f = f | (fzb != (w == 0)) | (fnb != w[DW-1]);
        f = f | (fzs != (s == 0)) | (fns != s[DW-1]);
`else
        f = f | (1'b0 & (fzb ^ fnb ^ fzs ^ fns));
`endif
        return f;
    endfunction

    task automatic send(input logic [FW-1:0] f, input logic [DW-1:0] w, s,
                        input logic fzb, fnb, fzs, fns, input logic v,
                        output bit taken);
        in_valid = v;
        func = f;
        wb = w;
        ws = s;
        zb = fzb;
        nb = fnb;
        zs = fzs;
        ns = fns;
        a = w ^ 16'h5a5a;
        b = s ^ 16'ha5a5;
        cin = f[0];
        taken = v && in_ready;
        if (taken) begin
            if (model_fail(w, s, fzb, fnb, fzs, fns)) m_cnt++;
            exp_q.push_back(m_cnt);
        end
        tick();
    endtask

    task automatic send_c(input logic [FW-1:0] f, input logic [DW-1:0] w, s,
                          input logic v, output bit taken);
        send(f, w, s, w == 0, w[DW-1], s == 0, s[DW-1], v, taken);
    endtask

    task automatic begin_run(input int n);
        num_vectors = CW'(n);
        start = 1'b1;
        m_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        int   n;
        int   fa;
        int   fb;
        int   cnt;
        int   idx;
        int   fn;
        int   mask;
        bit   pass;
    } run_t;

    run_t runs[3];
    logic [DW-1:0] w;
    bit tk;
    int nt;
    logic [6:0] hs_valid;

    initial begin
        runs[0] = '{10, -1, -1, 0, 0, 0, 8'h00, 1'b1};
        runs[1] = '{70, 23, 41, 2, 23, 2, 8'h14, 1'b0};
        runs[2] = '{12, 0, 11, 2, 0, 0, 8'h03, 1'b0};

        tick();
        check("reset_outs", 64'({busy, done, pass, in_ready, first_fail_valid,
              mismatch_count, first_fail_idx, first_fail_func,
              func_fail_mask}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 3; r++) begin
            begin_run(runs[r].n);
            check("run_busy", 64'(busy), 64'd1);
            for (int i = 0; i < runs[r].n; i++) begin
                w = DW'(i * 32'h1357);
                send_c(FW'((i / 10) % 8), w,
                       (i == runs[r].fa || i == runs[r].fb) ? (w ^ 16'h1) : w,
                       1'b1, tk);
                if (!tk) check("b2b_ready", 64'(tk), 64'd1);
            end
            in_valid = 1'b0;
            wait_done(12, "run");
            check("run_pass", 64'(pass), 64'(runs[r].pass));
            check("run_cnt", 64'(mismatch_count), 64'(runs[r].cnt));
            check("run_ffv", 64'(first_fail_valid), 64'(runs[r].cnt != 0));
            check("run_ffidx", 64'(first_fail_idx), 64'(runs[r].idx));
            check("run_fffunc", 64'(first_fail_func), 64'(runs[r].fn));
            check("run_mask", 64'(func_fail_mask), 64'(runs[r].mask));
            check("run_busy_low", 64'(busy), 64'd0);
        end

        // Flag-only disagreement with identical results.
        begin_run(1);
        send(3'd3, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, tk);
        in_valid = 1'b0;
        wait_done(8, "flag");
`ifdef CHECK_FLAGS_EN
        check("flag_cnt", 64'(mismatch_count), 64'd1);
        check("flag_mask", 64'(func_fail_mask), 64'h08);
`else
        check("flag_cnt", 64'(mismatch_count), 64'd0);
        check("flag_mask", 64'(func_fail_mask), 64'h00);
`endif

        // Handshake: idle slots and the 5th valid carry mismatching data.
        hs_valid = 7'b1101101;
        nt = 0;
        begin_run(4);
        for (int k = 0; k < 7; k++) begin
            w = DW'(16'h0100 + k);
            send_c(3'd1, w, (k == 1 || k == 4 || k == 6) ? (w ^ 16'h1) : w,
                   hs_valid[k], tk);
            if (tk) nt++;
            if (k == 6) check("hs_5th_rejected", 64'(tk), 64'd0);
        end
        in_valid = 1'b0;
        check("hs_xfers", 64'(nt), 64'd4);
        check("hs_ready_low", 64'(in_ready), 64'd0);
        wait_done(8, "hs");
        check("hs_cnt", 64'(mismatch_count), 64'd0);
        check("hs_pass", 64'(pass), 64'd1);

        // Empty run completes within two cycles of entering RUN.
        begin_run(0);
        wait_done(2, "zero");
        check("zero_pass", 64'(pass), 64'd1);

        // A start pulse during RUN must not restart or relatch the count.
        begin_run(6);
        nt = 0;
        for (int i = 0; i < 6; i++) begin
            w = DW'(16'h8000 + i * 7);
            if (i == 3) begin
                start = 1'b1;
                num_vectors = CW'(2);
            end
            send_c(3'd6, w, (i == 0) ? (w ^ 16'h1) : w, 1'b1, tk);
            start = 1'b0;
            if (tk) nt++;
        end
        in_valid = 1'b0;
        check("ign_xfers", 64'(nt), 64'd6);
        wait_done(8, "ign");
        check("ign_cnt", 64'(mismatch_count), 64'd1);
        check("ign_ffidx", 64'(first_fail_idx), 64'd0);
        check("ign_mask", 64'(func_fail_mask), 64'h40);

        // Reset mid-run after five failures.
        begin_run(20);
        for (int i = 0; i < 5; i++) begin
            w = DW'(16'h0040 + i);
            send_c(3'd2, w, w ^ 16'h1, 1'b1, tk);
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_cnt", 64'(mismatch_count), 64'd5);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_outs", 64'({busy, done, pass, in_ready, first_fail_valid,
              mismatch_count, first_fail_idx, first_fail_func,
              func_fail_mask}), 64'd0);
        exp_q.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 64'({busy, done}), 64'd0);
        begin_run(3);
        for (int i = 0; i < 3; i++) begin
            w = DW'(16'h1000 + i);
            send_c(3'd5, w, (i == 0) ? (w ^ 16'h1) : w, 1'b1, tk);
        end
        in_valid = 1'b0;
        wait_done(8, "rerun");
        check("rerun_cnt", 64'(mismatch_count), 64'd1);
        check("rerun_ffidx", 64'(first_fail_idx), 64'd0);
        check("rerun_fffunc", 64'(first_fail_func), 64'd5);
        check("rerun_mask", 64'(func_fail_mask), 64'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_lockstep_checker.md
Name: alu_lockstep_checker

Overview:
- Receiving and checking end of the ALU comparison interface. A driver streams operand vectors {a, b, cin, func} together with the outputs of two ALU implementations, behavioral and structural.
- The block accepts each vector through a valid/ready handshake and compares the two results in a 2-stage pipeline.
- It reports the mismatch count, the first failing vector and a per-function failure mask.
- It sits beside the two ALU instances in hardware self-test, replacing a simulation-only comparison.

Parameters:
- DATA_W, 16, ALU operand/result width.
- FUNC_W, 3, function-select width; 2**FUNC_W functions.
- CNT_W, 16, width of the vector and mismatch counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a run (ignored in RUN/DRAIN).
- num_vectors  input  CNT_W  vectors expected in the run; sampled on start.
- in_valid  input  1  vector and results valid.
- in_ready  output  1  checker accepts the vector this cycle.
- a, b  input  DATA_W  operands (logged only).
- cin  input  1  carry in (logged only).
- func  input  FUNC_W  ALU function.
- wb, ws  input  DATA_W  behavioral / structural result.
- zb, nb, zs, ns  input  1  zero/negative flags of each ALU.
- busy  output  1  state is RUN or DRAIN.
- done  output  1  run complete; held until the next start.
- pass  output  1  done and mismatch_count == 0.
- mismatch_count  output  CNT_W  failing vectors, saturating.
- first_fail_valid  output  1  a failure has been captured.
- first_fail_idx  output  CNT_W  index (0-based) of the first failing vector.
- first_fail_func  output  FUNC_W  func of the first failing vector.
- func_fail_mask  output  2**FUNC_W  bit f is set if any vector with func==f failed.

Behaviour:
- Reset (async, rst_n=0): all outputs and counters are 0, state is IDLE, pipeline valids are cleared.
- FSM:
  - IDLE: on start go to RUN; clear counters, mask and first-fail; latch num_vectors.
  - RUN: in_ready = (accepted < num_vectors). A transfer occurs when in_valid & in_ready, and accepted increments on each transfer. When accepted reaches num_vectors, go to DRAIN.
  - DRAIN: in_ready = 0. When both pipeline stages are empty, go to DONE.
  - DONE: done = 1, busy = 0. start clears the results and re-enters RUN, with the same actions as IDLE.
- start with num_vectors = 0: RUN → DRAIN → DONE within 2 cycles; pass = 1.
- Pipeline, fixed latency:
  - Stage 1 (cycle after transfer): registers wb, ws, flags, func and index; computes fail = (wb != ws).
  - Stage 2 (next cycle): updates the statistics.
  - Statistics update 2 cycles after the transfer.
- Stage 2 on fail:
  - mismatch_count increments, saturating at 2**CNT_W-1 with no wrap.
  - func_fail_mask[func] is set.
  - first_fail_* is written only if first_fail_valid == 0.
- Back-to-back transfers on every cycle are supported; there is no stall, because stage 2 always completes.
- in_valid while in_ready = 0 is ignored; the driver must hold the vector.
- rst_n asserted mid-run aborts immediately to the reset values. The partial run is lost.
- start while busy is ignored.
- a, b and cin do not affect the result; they are kept only for the debug capture.

Optional Feature:
- Macro CHECK_FLAGS_EN.
- Defined:
  - fail also includes (zb != zs) | (nb != ns).
  - It also includes self-consistency of each ALU: zb != (wb == 0), nb != wb[DATA_W-1], and likewise for zs/ns.
- Undefined: only wb vs ws is compared; flag inputs are unused. Port list is unchanged.

Decomposition:
- Package alu_check_pkg holds:
  - DATA_W/FUNC_W/CNT_W defaults.
  - FSM state typedef {IDLE, RUN, DRAIN, DONE}.
  - ALU function code constants 0..7.
- Sub-module alu_result_cmp: purely combinational compare producing fail, with CHECK_FLAGS_EN handled inside it. The FSM and counters stay in the top module.

Test Plan:
1. num_vectors=10, 10 vectors on consecutive cycles with wb==ws → after last transfer +2 cycles, plus DRAIN: done=1, pass=1, mismatch_count=0, mask=0x00.
2. num_vectors=70, 7 funcs × 10 vectors; ws=wb^1 only at vector 23 (func=2) and vector 41 (func=4) → mismatch_count=2, first_fail_idx=23, first_fail_func=2, mask=0x14, pass=0.
3. Flag-only error: wb==ws=16'h0000, zb=1, zs=0 → with CHECK_FLAGS_EN mismatch_count=1; without it mismatch_count=0.
4. Handshake: in_valid toggling 1,0,1,1,0,1 with num_vectors=4 → exactly 4 transfers; in_ready=0 after the 4th; a 5th in_valid is not counted.
5. start with num_vectors=0 → done=1, pass=1 within 2 cycles; start during RUN is ignored (counters not cleared).
6. rst_n=0 for 1 cycle mid-run after 5 failures → all outputs 0, state IDLE; a new start runs cleanly from index 0.
